// File: rtl/d_ff.sv
// d_ff: WIDTH-bit D flip-flop with asynchronous active-low reset to RESET_VALUE.
// Define D_FF_CHECKS_EN to compile simulation-only checkers (error_count, reported at $finish).
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             reset,
  input  logic             clk
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

`ifdef D_FF_CHECKS_EN
  int unsigned error_count = 0;
  realtime     clk_rise_t  = -1.0;
  realtime     rst_rise_t  = -1.0;

  initial begin
    if (WIDTH < 1) $fatal(1, "%m: WIDTH must be >= 1 (got %0d)", WIDTH);
  end

  // The release/edge race is reported once: whichever event is processed second sees the match.
  always @(posedge clk) begin
    clk_rise_t = $realtime;
    if (reset === 1'b1 && $isunknown(d)) begin
      error_count++;
      $error("%m: d has X/Z bits at clock edge (d=%b)", d);
    end
    if (rst_rise_t == $realtime) begin
      $warning("%m: reset released on a rising clk edge");
    end
  end

  always @(posedge reset) begin
    rst_rise_t = $realtime;
    if (clk_rise_t == $realtime) begin
      $warning("%m: reset released on a rising clk edge");
    end
  end

  always @(reset) begin
    if ($time > 0 && $isunknown(reset)) begin
      error_count++;
      $error("%m: reset is X/Z");
    end
  end

  final $info("%m: %0d checker errors", error_count);
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: self-checking bench for d_ff using 1-, 8- (RESET_VALUE=8'hA5) and 64-bit instances.
// Expected outputs are queued when stimulus is driven and popped after the capturing edge.
module tb_d_ff;

  typedef struct packed {
    logic        q1;
    logic [7:0]  q8;
    logic [63:0] q64;
  } out_t;

  typedef struct {
    logic        d1;
    logic [7:0]  d8;
    logic [63:0] d64;
    out_t        exp;
  } vec_t;

  localparam out_t RST_EXP = '{q1: 1'b0, q8: 8'hA5, q64: 64'h0};
  localparam int   NVEC    = 6;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        d1    = 1'b0;
  logic [7:0]  d8    = 8'h00;
  logic [63:0] d64   = 64'h0;
  logic        q1;
  logic [7:0]  q8;
  logic [63:0] q64;
  out_t        dut_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];
  out_t e;
  vec_t vecs[NVEC];

  d_ff u_ff1 (.q(q1), .d(d1), .reset(reset), .clk(clk));
  d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_ff8 (.q(q8), .d(d8), .reset(reset), .clk(clk));
  d_ff #(.WIDTH(64)) u_ff64 (.q(q64), .d(d64), .reset(reset), .clk(clk));

  assign dut_o = {q1, q8, q64};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic check_out(input string name, input out_t exp);
    check({name, ".q1"},  {63'h0, dut_o.q1}, {63'h0, exp.q1});
    check({name, ".q8"},  {56'h0, dut_o.q8}, {56'h0, exp.q8});
    check({name, ".q64"}, dut_o.q64,         exp.q64);
  endtask

  initial begin
    vecs[0] = '{d1: 1'b0, d8: 8'h3C, d64: 64'hDEADBEEF_01234567, exp: '{1'b0, 8'h3C, 64'hDEADBEEF_01234567}};
    vecs[1] = '{d1: 1'b1, d8: 8'hC3, d64: 64'h0,                 exp: '{1'b1, 8'hC3, 64'h0}};
    vecs[2] = '{d1: 1'b1, d8: 8'hFF, d64: 64'hFFFFFFFF_FFFFFFFF, exp: '{1'b1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF}};
    vecs[3] = '{d1: 1'b0, d8: 8'h00, d64: 64'h80000000_00000001, exp: '{1'b0, 8'h00, 64'h80000000_00000001}};
    vecs[4] = '{d1: 1'b1, d8: 8'hA5, d64: 64'h01234567_89ABCDEF, exp: '{1'b1, 8'hA5, 64'h01234567_89ABCDEF}};
    vecs[5] = '{d1: 1'b0, d8: 8'h5A, d64: 64'h0,                 exp: '{1'b0, 8'h5A, 64'h0}};

    // Asynchronous assertion well away from any clock edge.
    #2 reset = 1'b0;
    #1 check_out("async_reset_assert", RST_EXP);

    d1 = 1'b1; d8 = 8'hFF; d64 = '1;
    repeat (2) @(posedge clk);
    #1 check_out("edges_ignored_in_reset", RST_EXP);

    // Release lands in the same time step as a rising edge; that edge must not capture.
    @(posedge clk);
    reset <= 1'b1;
    #1 check_out("release_on_edge_no_capture", RST_EXP);
    exp_q.push_back('{1'b1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF});
    @(posedge clk);
    #1 e = exp_q.pop_front();
    check_out("first_capture_after_release", e);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      d1 = vecs[i].d1; d8 = vecs[i].d8; d64 = vecs[i].d64;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1 e = exp_q.pop_front();
      check_out($sformatf("vec%0d", i), e);
      #2 d1 = ~d1; d8 = ~d8; d64 = ~d64;
      #1 check_out($sformatf("vec%0d_hold", i), e);
    end

    // Glitchy data between edges: only the settled value is captured.
    @(negedge clk);
    d8 = 8'h81; d64 = 64'h1;
    d1 = 1'b0; #1 d1 = 1'b1; #1 d1 = 1'b0; #1 d1 = 1'b1;
    exp_q.push_back('{1'b1, 8'h81, 64'h1});
    @(posedge clk);
    #1 e = exp_q.pop_front();
    check_out("glitch_settled", e);

    // Mid-cycle reset overrides the captured value immediately.
    #2 reset = 1'b0;
    #1 check_out("async_reset_midcycle", RST_EXP);
    repeat (2) @(posedge clk);
    #1 check_out("reset_held", RST_EXP);

    @(negedge clk);
    reset = 1'b1;
    d1 = 1'b1; d8 = 8'h42; d64 = 64'hCAFEF00D_12345678;
    exp_q.push_back('{1'b1, 8'h42, 64'hCAFEF00D_12345678});
    @(posedge clk);
    #1 e = exp_q.pop_front();
    check_out("capture_after_midcycle_release", e);

    // Unknown data at an edge with reset high.
    @(negedge clk);
    d1 = 1'bx;
    exp_q.push_back('{1'bx, 8'h42, 64'hCAFEF00D_12345678});
    @(posedge clk);
    #1 e = exp_q.pop_front();
    check_out("x_data_capture", e);
`ifdef D_FF_CHECKS_EN
    check("checker_error_count", {32'h0, u_ff1.error_count}, 64'd1);
`endif
    @(negedge clk);
    d1 = 1'b0;
    exp_q.push_back('{1'b0, 8'h42, 64'hCAFEF00D_12345678});
    @(posedge clk);
    #1 e = exp_q.pop_front();
    check_out("recover_from_x", e);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
